// File: rtl/ut_pkg.sv
// Shared types and default widths for the processing unit's memory path.
package ut_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    LOAD    = 2'd1,
    RESTART = 2'd2,
    RUN     = 2'd3
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous pad levels.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two back-to-back flops; the first may go metastable, the second settles it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/boot_mem_arbiter.sv
// Boot loader / memory-port arbiter: fills RAM from a byte stream after reset
// or on a boot request, then hands the port to the control unit.
module boot_mem_arbiter
  import ut_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LOAD_LEN = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic              cpu_en,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [ADDR_W-1:0] mem_adr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_ce,
  output logic              cpu_restart,
  output logic              load_done
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(LOAD_LEN - 1);

  logic              boot_s;
  logic              boot_d;
  logic              boot_rise;
  logic              xfer;
  state_t            state_q, state_d;
  logic [1:0]        hold_cnt_q, hold_cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              load_done_q, load_done_d;

  sync_2ff #(.W(1)) u_boot_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (boot),
    .q     (boot_s)
  );

  // Delayed copy of the synchronised boot level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) boot_d <= 1'b0;
    else        boot_d <= boot_s;
  end

  assign boot_rise = boot_s & ~boot_d;
  assign xfer      = (state_q == LOAD) & rx_valid;

  // FSM state, HOLD counter, load pointer and completion flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HOLD;
      hold_cnt_q  <= 2'd0;
      ptr_q       <= '0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      ptr_q       <= ptr_d;
      load_done_q <= load_done_d;
    end
  end

  // Next-state logic; a byte accepted alongside a boot fall is still counted
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    ptr_d       = ptr_q;
    load_done_d = load_done_q;
    case (state_q)
      HOLD: begin
        // Two cycles let the synchroniser fill before boot_s is trusted
        if (hold_cnt_q == 2'd2) state_d = boot_s ? LOAD : RESTART;
        else                    hold_cnt_d = hold_cnt_q + 2'd1;
      end
      LOAD: begin
        if (xfer && (ptr_q == LAST_PTR)) begin
          load_done_d = 1'b1;
          state_d     = RESTART;
        end else begin
          if (xfer)    ptr_d   = ptr_q + 1'b1;
          if (!boot_s) state_d = RESTART;
        end
      end
      RESTART: begin
        ptr_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (boot_rise) begin
          load_done_d = 1'b0;
          ptr_d       = '0;
          state_d     = LOAD;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  // Memory port steering and control-unit strobes decoded from registered state
  always_comb begin
    rx_ready    = 1'b0;
    cpu_ce      = 1'b0;
    cpu_restart = 1'b0;
    mem_adr     = '0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    case (state_q)
      LOAD: begin
        rx_ready  = 1'b1;
        mem_en    = rx_valid;
        mem_we    = rx_valid;
        mem_adr   = ptr_q;
        mem_wdata = rx_data;
      end
      RESTART: cpu_restart = 1'b1;
      RUN: begin
        cpu_ce    = 1'b1;
        mem_adr   = cpu_adr;
        mem_en    = cpu_en;
        mem_we    = cpu_we & cpu_en;
        mem_wdata = cpu_wdata;
      end
      default: ;
    endcase
  end

  assign load_done = load_done_q;

endmodule

// File: tb/tb_boot_mem_arbiter.sv
// Directed testbench for boot_mem_arbiter with a behavioural RAM.
module tb_boot_mem_arbiter;

  logic       clk;
  logic       rst_n;
  logic       boot;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [5:0] cpu_adr;
  logic       cpu_en;
  logic       cpu_we;
  logic [7:0] cpu_wdata;
  logic [5:0] mem_adr;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic       cpu_ce;
  logic       cpu_restart;
  logic       load_done;

  int n_checks;
  int n_pass;
  int wr_count;
  int base;
  int errs;
  int ready_miss;
  int cyc;

  logic [7:0] ram [64];

  typedef struct {
    logic [5:0] adr;
    logic       en;
    logic       we;
    logic [7:0] wd;
    logic [5:0] e_adr;
    logic       e_en;
    logic       e_we;
    logic [7:0] e_wd;
  } mux_vec_t;

  mux_vec_t vecs [5];

  boot_mem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .boot        (boot),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .cpu_adr     (cpu_adr),
    .cpu_en      (cpu_en),
    .cpu_we      (cpu_we),
    .cpu_wdata   (cpu_wdata),
    .mem_adr     (mem_adr),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .cpu_ce      (cpu_ce),
    .cpu_restart (cpu_restart),
    .load_done   (load_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with synchronous write; counts every write it performs
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      ram[mem_adr] = mem_wdata;
      wr_count = wr_count + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {rx_ready, mem_en, mem_we, mem_adr, mem_wdata, cpu_ce, cpu_restart, load_done}, 32'h0);
  endtask

  task automatic send_byte(input logic [7:0] d, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    @(negedge clk);
    repeat (gap) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = d;
    if (rx_ready !== 1'b1) ready_miss++;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 20 && rx_ready !== 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
    check(name, rx_ready, 1);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    wr_count = 0;
    vecs[0] = '{6'h15, 1'b1, 1'b1, 8'hA5, 6'h15, 1'b1, 1'b1, 8'hA5};
    vecs[1] = '{6'h3F, 1'b1, 1'b0, 8'h5A, 6'h3F, 1'b1, 1'b0, 8'h5A};
    vecs[2] = '{6'h00, 1'b0, 1'b1, 8'hFF, 6'h00, 1'b0, 1'b0, 8'hFF};
    vecs[3] = '{6'h2A, 1'b0, 1'b0, 8'h11, 6'h2A, 1'b0, 1'b0, 8'h11};
    vecs[4] = '{6'h01, 1'b1, 1'b1, 8'h00, 6'h01, 1'b1, 1'b1, 8'h00};

    rst_n     = 1'b0;
    boot      = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    cpu_adr   = 6'h15;
    cpu_en    = 1'b1;
    cpu_we    = 1'b1;
    cpu_wdata = 8'hA5;

    // Reset release with boot low
    #1;
    check_reset_outputs("reset_init");
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("cpu_ce_c%0d", c), cpu_ce, (c >= 3) ? 1 : 0);
      check($sformatf("cpu_restart_c%0d", c), cpu_restart, (c == 2) ? 1 : 0);
      check($sformatf("mem_en_c%0d", c), mem_en, (c >= 3) ? 1 : 0);
    end
    check("run_mirror", {mem_adr, mem_we, mem_wdata}, {6'h15, 1'b1, 8'hA5});
    check("run_load_done", load_done, 0);

    // RUN pass-through table
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cpu_adr   = vecs[i].adr;
      cpu_en    = vecs[i].en;
      cpu_we    = vecs[i].we;
      cpu_wdata = vecs[i].wd;
      #1;
      check($sformatf("mux_vec%0d", i), {mem_adr, mem_en, mem_we, mem_wdata},
            {vecs[i].e_adr, vecs[i].e_en, vecs[i].e_we, vecs[i].e_wd});
    end

    // rx stream is ignored in RUN
    @(negedge clk);
    cpu_en   = 1'b0;
    cpu_we   = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h66;
    base     = wr_count;
    #1;
    check("run_rx_ready", rx_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    check("run_rx_no_write", wr_count - base, 0);
    rx_valid = 1'b0;

    // Boot held high through reset: full 64-byte load with gaps
    @(negedge clk);
    rst_n = 1'b0;
    boot  = 1'b1;
    #1;
    check_reset_outputs("reset_boot");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("boot_rx_ready_c%0d", c), rx_ready, (c == 2) ? 1 : 0);
    end
    base       = wr_count;
    ready_miss = 0;
    for (int i = 0; i < 64; i++) send_byte(8'(i), 2);
    check("load_restart", cpu_restart, 1);
    check("load_done_set", load_done, 1);
    check("load_ce_low", cpu_ce, 0);
    check("load_writes", wr_count - base, 64);
    check("load_ready_miss", ready_miss, 0);
    errs = 0;
    for (int i = 0; i < 64; i++) if (ram[i] !== 8'(i)) errs++;
    check("load_ram", errs, 0);
    @(posedge clk);
    #1;
    check("load_then_run", {cpu_ce, cpu_restart}, 2'b10);

    // Boot rise in RUN with a CPU write in the final RUN cycle
    @(negedge clk);
    boot = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    boot = 1'b1;
    @(posedge clk);
    #1;
    check("rise_ce_e1", cpu_ce, 1);
    @(posedge clk);
    #1;
    check("rise_ce_e2", cpu_ce, 1);
    @(negedge clk);
    cpu_adr   = 6'h05;
    cpu_en    = 1'b1;
    cpu_we    = 1'b1;
    cpu_wdata = 8'h77;
    @(posedge clk);
    #1;
    check("rise_last_cpu_write", ram[5], 8'h77);
    check("rise_ce_low", cpu_ce, 0);
    check("rise_rx_ready", rx_ready, 1);
    check("rise_load_done_clr", load_done, 0);
    cpu_en = 1'b0;
    cpu_we = 1'b0;

    // Abort after 10 bytes
    base       = wr_count;
    ready_miss = 0;
    for (int i = 0; i < 10; i++) send_byte(8'hA0 + 8'(i), 1);
    @(negedge clk);
    boot = 1'b0;
    cyc  = 0;
    for (int i = 0; i < 10 && cpu_restart !== 1'b1; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("abort_restart", cpu_restart, 1);
    check("abort_latency", cyc, 3);
    check("abort_load_done", load_done, 0);
    check("abort_writes", wr_count - base, 10);
    check("abort_ready_miss", ready_miss, 0);
    errs = 0;
    for (int i = 0; i < 10; i++) if (ram[i] !== (8'hA0 + 8'(i))) errs++;
    check("abort_ram", errs, 0);
    check("abort_adr10_kept", ram[10], 8'h0A);

    // Last byte accepted in the first cycle with boot_s low
    @(negedge clk);
    boot = 1'b1;
    wait_ready("reload_ready");
    base       = wr_count;
    ready_miss = 0;
    for (int i = 0; i < 63; i++) send_byte(8'(i * 3), 1);
    @(negedge clk);
    boot = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h5C;
    check("last_ready", rx_ready, 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check("last_restart", cpu_restart, 1);
    check("last_load_done", load_done, 1);
    check("last_byte", ram[63], 8'h5C);
    check("last_writes", wr_count - base, 64);
    check("last_ready_miss", ready_miss, 0);
    errs = 0;
    for (int i = 0; i < 63; i++) if (ram[i] !== 8'(i * 3)) errs++;
    check("last_ram", errs, 0);

    // Reset mid-load at ptr 20, then reload from address 0
    @(posedge clk);
    #1;
    @(negedge clk);
    boot = 1'b1;
    wait_ready("mid_ready");
    for (int i = 0; i < 20; i++) send_byte(8'h40 + 8'(i), 0);
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h33;
    #1;
    check_reset_outputs("reset_midload");
    rx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    base  = wr_count;
    wait_ready("after_reset_ready");
    send_byte(8'h99, 0);
    check("after_reset_adr0", ram[0], 8'h99);
    check("after_reset_adr1", ram[1], 8'h41);
    check("after_reset_adr20", ram[20], 8'h3C);
    check("after_reset_writes", wr_count - base, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/boot_mem_arbiter.md
# boot_mem_arbiter

Sequencer and arbiter for the processing unit's single program/data memory port. After reset, it either loads the memory from an external byte stream (boot mode) or releases the control unit immediately. It then grants the memory port to the control unit and gates the unit's clock enable around every load. It sits in the top wrapper between the pads, the control unit and the RAM.

## Interface
- ADDR_W, 6, memory address width; the control unit's address field
- DATA_W, 8, memory word width
- LOAD_LEN, 64, bytes per boot load; legal range 1..2**ADDR_W
- clk  in  1  system clock; all state is on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- boot  in  1  load request from pad; asynchronous level, synchronised internally
- rx_data  in  DATA_W  boot byte
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  block accepts a byte; a transfer occurs when rx_valid & rx_ready
- cpu_adr  in  ADDR_W  control unit memory address
- cpu_en  in  1  control unit memory enable
- cpu_we  in  1  control unit write strobe
- cpu_wdata  in  DATA_W  control unit write data (accumulator)
- mem_adr  out  ADDR_W  RAM address
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable; synchronous write at the next clk edge
- mem_wdata  out  DATA_W  RAM write data
- cpu_ce  out  1  control unit clock enable
- cpu_restart  out  1  one-cycle pulse, active high, that resets the control unit PC/state
- load_done  out  1  the last load completed all LOAD_LEN bytes

## Operation
- boot passes through a 2-flop synchroniser to give boot_s. A registered copy of boot_s provides rising- and falling-edge detection.
- FSM states: HOLD, LOAD, RESTART, RUN.
- HOLD (reset state):
  - Lasts exactly 2 cycles, long enough for the synchroniser to fill.
  - Then moves to LOAD if boot_s = 1, otherwise to RESTART.
- LOAD:
  - rx_ready = 1.
  - On each transfer: mem_en = mem_we = 1, mem_adr = ptr, mem_wdata = rx_data, then ptr increments.
  - If the transfer is at ptr = LOAD_LEN-1: set load_done and go to RESTART.
  - Else if boot_s = 0: abort to RESTART; load_done stays 0 and memory above ptr is untouched.
  - A transfer in the same cycle as a boot_s fall is always written. If it is the last byte, the load counts as complete (load_done = 1).
- RESTART:
  - Lasts 1 cycle.
  - cpu_restart = 1, cpu_ce = 0, ptr cleared.
  - Then goes to RUN.
- RUN:
  - cpu_ce = 1.
  - Memory port is a combinational pass-through: mem_adr = cpu_adr, mem_en = cpu_en, mem_we = cpu_we & cpu_en, mem_wdata = cpu_wdata.
  - A boot_s rising edge moves to LOAD at the next edge, clears load_done and sets ptr = 0. The CPU access in that last RUN cycle is still served.
- In HOLD and RESTART, mem_en = mem_we = 0 and rx_ready = 0.
- Outside LOAD, rx_valid is ignored and no byte is consumed.
- ptr is ADDR_W bits and never wraps: the load ends at LOAD_LEN-1.

## Timing
- Reset values (asynchronous): state = HOLD, ptr = 0, load_done = 0, synchroniser = 0, cpu_ce = 0, cpu_restart = 0, rx_ready = 0, mem_en = mem_we = 0, mem_adr = 0, mem_wdata = 0.
- Cycle numbering starts at the first clk edge after rst_n rises.
- Boot at reset:
  - boot = 0: HOLD in cycles 0–1, RESTART in cycle 2, RUN (cpu_ce = 1) from cycle 3.
  - boot = 1: LOAD from cycle 2.
- A boot pin change reaches boot_s after 2 edges. From RUN, cpu_ce falls and rx_ready rises 3 cycles after the pin rises.
- Load throughput: 1 byte per cycle. RAM write latency: 1 edge.
- State-dependent outputs are decoded from registered state (glitch-free relative to state). The memory mux is combinational.
- Asserting rst_n low mid-LOAD or mid-RUN forces reset values immediately. The load is not resumed.

## Structure
- Shared package ut_pkg holds:
  - the state enum (HOLD, LOAD, RESTART, RUN)
  - default ADDR_W and DATA_W
- Sub-module sync_2ff: generic 2-flop synchroniser with async active-low reset, reusable for other pad inputs.
- The top wrapper instantiates boot_mem_arbiter between the pads, the control unit (ce from cpu_ce, reset from rst or cpu_restart) and the RAM.

## Test plan
- Reset release with boot = 0 → cpu_ce = 0 in cycles 0–2, cpu_restart = 1 in cycle 2 only, cpu_ce = 1 from cycle 3. The memory port mirrors cpu_adr = 0x15, cpu_en = 1, cpu_we = 1, cpu_wdata = 0xA5.
- boot = 1 through reset; stream bytes 0x00..0x3F with random rx_valid gaps → 64 writes with adr i, data i. Then one cpu_restart pulse, load_done = 1, RUN.
- In RUN, raise boot with a CPU write in flight → that write reaches the RAM. 3 cycles later cpu_ce = 0, rx_ready = 1, load_done = 0.
- Drop boot after 10 bytes → only addresses 0..9 are written, then RESTART, load_done = 0, and address 10 keeps its old value.
- Last byte (ptr = 63) accepted in the same cycle boot_s falls → byte written, load_done = 1.
- Assert rst_n low mid-LOAD at ptr = 20 → all outputs reach reset values without a clock edge. After release with boot = 1, loading restarts at address 0.
